// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: FSM states and PC-source select codes.
package fetch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_IMM = 2'b01;
  localparam logic [1:0] PCSEL_JLR = 2'b10;
  localparam logic [1:0] PCSEL_BEQ = 2'b11;

  // EX sources should be one-hot; if not, JLR wins over BEQ, BEQ over JAL.
  function automatic logic [1:0] ex_pc_sel(input logic jal, input logic jlr, input logic beq);
    logic [1:0] sel;
    sel = PCSEL_INC;
    if (jlr) begin
      sel = PCSEL_JLR;
    end else if (beq) begin
      sel = PCSEL_BEQ;
    end else if (jal) begin
      sel = PCSEL_IMM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating count of consecutive imem wait cycles with a sticky timeout flag.
module fetch_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (cnt_d == CntMax);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: PC enable/select, redirect arbitration, flushes and wrong-path drain.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       imem_ready_in,
  input  logic       stall_id_in,
  input  logic       halt_id_in,
  input  logic       jal_ex_in,
  input  logic       jlr_ex_in,
  input  logic       beq_taken_ex_in,
  input  logic       r7_wr_wb_in,
  output logic       en_pc_out,
  output logic [1:0] pc_select_ex_out,
  output logic       r7_detect_wb_out,
  output logic       if_valid_out,
  output logic       flush_if_id_out,
  output logic       flush_id_rr_out,
  output logic       flush_rr_ex_out,
  output logic       flush_ex_mem_out,
  output logic       imem_timeout_out,
  output logic [1:0] state_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] redirect_cnt_out,
  output logic [PERF_W-1:0] stall_cnt_out
`endif
);

  fetch_state_e state_q, state_d;
  logic         live;
  logic         ex_req;
  logic         redirect_r7;
  logic         redirect_ex;
  logic         redirect;

  // BOOT never redirects: the PC has not been loaded yet.
  assign live        = (state_q != StBoot);
  assign ex_req      = jal_ex_in | jlr_ex_in | beq_taken_ex_in;
  assign redirect_r7 = live & r7_wr_wb_in;
  assign redirect_ex = live & ~r7_wr_wb_in & ex_req;
  assign redirect    = redirect_r7 | redirect_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (redirect) begin
          // A redirect with a fetch still outstanding leaves a wrong-path response to discard.
          state_d = imem_ready_in ? StRun : StDrain;
        end else if (halt_id_in && !stall_id_in) begin
          state_d = StHalt;
        end
      end
      StDrain: begin
        if (imem_ready_in) begin
          state_d = StRun;
        end
      end
      StHalt: begin
        if (redirect) begin
          state_d = imem_ready_in ? StRun : StDrain;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    en_pc_out        = 1'b0;
    pc_select_ex_out = PCSEL_INC;
    r7_detect_wb_out = 1'b0;
    if_valid_out     = 1'b0;
    flush_if_id_out  = 1'b0;
    flush_id_rr_out  = 1'b0;
    flush_rr_ex_out  = 1'b0;
    flush_ex_mem_out = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if_valid_out = imem_ready_in;
          en_pc_out    = imem_ready_in & ~stall_id_in & ~halt_id_in;
        end
        StHalt:  flush_if_id_out = 1'b1;
        default: ;
      endcase
      if (redirect_r7) begin
        r7_detect_wb_out = 1'b1;
        en_pc_out        = 1'b1;
        flush_if_id_out  = 1'b1;
        flush_id_rr_out  = 1'b1;
        flush_rr_ex_out  = 1'b1;
        flush_ex_mem_out = 1'b1;
      end else if (redirect_ex) begin
        pc_select_ex_out = ex_pc_sel(jal_ex_in, jlr_ex_in, beq_taken_ex_in);
        en_pc_out        = 1'b1;
        flush_if_id_out  = 1'b1;
        flush_id_rr_out  = 1'b1;
        flush_rr_ex_out  = 1'b1;
      end
    end
  end

  assign state_out = state_q;

  fetch_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .count_i   (((state_q == StRun) || (state_q == StDrain)) && !imem_ready_in),
    .clear_i   (imem_ready_in),
    .timeout_o (imem_timeout_out)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] redirect_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
      if (((state_q == StRun) || (state_q == StDrain)) && !en_pc_out) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign redirect_cnt_out = redirect_cnt_q;
  assign stall_cnt_out    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios then random stimulus vs a cycle model.
module tb_fetch_seq_ctrl;

  localparam int WaitMax = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_ready_in, stall_id_in, halt_id_in;
  logic       jal_ex_in, jlr_ex_in, beq_taken_ex_in, r7_wr_wb_in;
  logic       en_pc_out, r7_detect_wb_out, if_valid_out;
  logic [1:0] pc_select_ex_out, state_out;
  logic       flush_if_id_out, flush_id_rr_out, flush_rr_ex_out, flush_ex_mem_out;
  logic       imem_timeout_out;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt_out, stall_cnt_out;
`endif

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .imem_ready_in    (imem_ready_in),
    .stall_id_in      (stall_id_in),
    .halt_id_in       (halt_id_in),
    .jal_ex_in        (jal_ex_in),
    .jlr_ex_in        (jlr_ex_in),
    .beq_taken_ex_in  (beq_taken_ex_in),
    .r7_wr_wb_in      (r7_wr_wb_in),
    .en_pc_out        (en_pc_out),
    .pc_select_ex_out (pc_select_ex_out),
    .r7_detect_wb_out (r7_detect_wb_out),
    .if_valid_out     (if_valid_out),
    .flush_if_id_out  (flush_if_id_out),
    .flush_id_rr_out  (flush_id_rr_out),
    .flush_rr_ex_out  (flush_rr_ex_out),
    .flush_ex_mem_out (flush_ex_mem_out),
    .imem_timeout_out (imem_timeout_out),
    .state_out        (state_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt_out (redirect_cnt_out),
    .stall_cnt_out    (stall_cnt_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 BOOT, 1 RUN, 2 DRAIN, 3 HALT.
  int m_state   = 0;
  int m_wait    = 0;
  bit m_timeout = 1'b0;
  int m_redir_cnt = 0;
  int m_stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model on the edge.
  task automatic step(input bit r, input bit r7, input bit jal, input bit jlr, input bit beq,
                      input bit stall, input bit halt, input bit ready);
    bit live, any_ex, redir;
    int e_sel, e_en, e_valid, e_r7, e_flush;
    rst = r; r7_wr_wb_in = r7; jal_ex_in = jal; jlr_ex_in = jlr; beq_taken_ex_in = beq;
    stall_id_in = stall; halt_id_in = halt; imem_ready_in = ready;
    @(negedge clk);
    live   = !r && (m_state != 0);
    any_ex = jal || jlr || beq;
    redir  = live && (r7 || any_ex);
    e_sel = 0; e_en = 0; e_valid = 0; e_r7 = 0; e_flush = 0;
    if (live) begin
      if (m_state == 1) begin
        e_valid = int'(ready);
        e_en    = int'(ready && !stall && !halt);
      end
      if (m_state == 3) e_flush = 8;
      if (r7) begin
        e_r7 = 1; e_en = 1; e_flush = 15;
      end else if (any_ex) begin
        e_en = 1; e_flush = 14;
        e_sel = jlr ? 2 : (beq ? 3 : 1);
      end
    end
    check("state", 32'(state_out), 32'(m_state));
    check("en_pc", 32'(en_pc_out), 32'(e_en));
    check("pc_select", 32'(pc_select_ex_out), 32'(e_sel));
    check("r7_detect", 32'(r7_detect_wb_out), 32'(e_r7));
    check("flushes", 32'({flush_if_id_out, flush_id_rr_out, flush_rr_ex_out, flush_ex_mem_out}),
          32'(e_flush));
    if (!(m_state == 1 && redir)) check("if_valid", 32'(if_valid_out), 32'(e_valid));
    check("timeout", 32'(imem_timeout_out), 32'(m_timeout));
`ifdef FETCH_PERF_CNT_EN
    check("redirect_cnt", 32'(redirect_cnt_out), 32'(m_redir_cnt & 16'hFFFF));
    check("stall_cnt", 32'(stall_cnt_out), 32'(m_stall_cnt & 16'hFFFF));
`endif
    @(posedge clk);
    if (r) begin
      m_state = 0; m_wait = 0; m_timeout = 1'b0; m_redir_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (redir) m_redir_cnt++;
      if ((m_state == 1 || m_state == 2) && e_en == 0) m_stall_cnt++;
      if (ready) m_wait = 0;
      else if (m_state == 1 || m_state == 2) m_wait = (m_wait < WaitMax) ? m_wait + 1 : WaitMax;
      if (m_wait == WaitMax) m_timeout = 1'b1;
      case (m_state)
        0: m_state = 1;
        1: begin
          if (redir) m_state = ready ? 1 : 2;
          else if (halt && !stall) m_state = 3;
        end
        2: if (ready) m_state = 1;
        default: if (redir) m_state = ready ? 1 : 2;
      endcase
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ready_in = 1'b1; stall_id_in = 1'b0; halt_id_in = 1'b0;
    jal_ex_in = 1'b0; jlr_ex_in = 1'b0; beq_taken_ex_in = 1'b0; r7_wr_wb_in = 1'b0;
    @(posedge clk); #1;
    // Reset, BOOT, then RUN fetching sequentially.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Taken BEQ.
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // R7 writeback beats a simultaneous JLR.
    step(0, 1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // JAL with a fetch outstanding -> drain the wrong-path response.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Load-use stall, then stall overridden by a BEQ.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0, 1);
    // Multiple EX requests at once: JLR > BEQ > JAL.
    step(0, 0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1, 0, 0, 1);
    // HALT, released by a JAL, then a long imem wait trips the timeout.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    // Reset out of DRAIN clears everything.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 97) == 0, ($urandom % 12) == 0, ($urandom % 10) == 0,
           ($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 4) == 0,
           ($urandom % 10) == 0, ($urandom % 4) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
